// File: rtl/instr_decoder_pkg.sv
// instr_decoder_pkg
// Shared definitions for the decode stage: ALU operation encodings,
// instruction field positions, register-field width, the decoded payload
// record and the combinational opcode decoder.
package instr_decoder_pkg;

  // Instruction word layout
  localparam int INSTR_W = 19;
  localparam int OPC_HI  = 18;
  localparam int OPC_LO  = 14;
  localparam int RD_HI   = 13;
  localparam int RD_LO   = 10;
  localparam int RS1_HI  = 9;
  localparam int RS1_LO  = 6;
  localparam int RS2_HI  = 5;
  localparam int RS2_LO  = 2;

  // Register field width (log2 of the 16-entry register file)
  localparam int REG_W = 4;
  localparam int OPC_W = 5;

  // ALU operation encodings shared with the execute stage.
  // Code 0 is deliberately unused so that an illegal instruction's
  // forced-zero control word never aliases a real operation.
  localparam logic [OPC_W-1:0] ADD   = 5'd1;
  localparam logic [OPC_W-1:0] SUB   = 5'd2;
  localparam logic [OPC_W-1:0] MUL   = 5'd3;
  localparam logic [OPC_W-1:0] DIV   = 5'd4;
  localparam logic [OPC_W-1:0] INC   = 5'd5;
  localparam logic [OPC_W-1:0] DEC   = 5'd6;
  localparam logic [OPC_W-1:0] AND   = 5'd7;
  localparam logic [OPC_W-1:0] OR    = 5'd8;
  localparam logic [OPC_W-1:0] XOR   = 5'd9;
  localparam logic [OPC_W-1:0] ENCRY = 5'd10;
  localparam logic [OPC_W-1:0] DECRY = 5'd11;

  // Decoded instruction as carried through the skid buffer
  typedef struct packed {
    logic             illegal;
    logic             use_rs2;
    logic [OPC_W-1:0] alu_ctrl;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
  } dec_t;

  localparam int DEC_W = $bits(dec_t);

  // Turn a raw instruction word into its decoded form.
  function automatic dec_t decode_instr(input logic [INSTR_W-1:0] instr);
    dec_t             d;
    logic [OPC_W-1:0] opc;
    opc   = instr[OPC_HI:OPC_LO];
    d.rd  = instr[RD_HI:RD_LO];
    d.rs1 = instr[RS1_HI:RS1_LO];
    d.rs2 = instr[RS2_HI:RS2_LO];
    case (opc)
      ADD, SUB, MUL, DIV, AND, OR, XOR: begin
        d.alu_ctrl = opc;
        d.illegal  = 1'b0;
        d.use_rs2  = 1'b1;
      end
      INC, DEC, ENCRY, DECRY: begin
        d.alu_ctrl = opc;
        d.illegal  = 1'b0;
        d.use_rs2  = 1'b0;
      end
      default: begin
        d.alu_ctrl = 5'd0;
        d.illegal  = 1'b1;
        d.use_rs2  = 1'b0;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/instr_decoder_skid_buffer.sv
// skid_buffer
// Generic two-entry valid/ready stage: one output register plus one skid
// entry. in_ready is registered and equals "skid entry empty"; it is low
// while in reset and rises on the first clock edge after reset is released.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   in_valid/in_ready   - upstream handshake, in_data payload
//   out_valid/out_ready - downstream handshake, out_data payload (registered)
module skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         skid_valid;
  logic [W-1:0] skid_data;

  logic         in_fire;
  logic         out_fire;
  logic         out_valid_nxt;
  logic [W-1:0] out_data_nxt;
  logic         skid_valid_nxt;
  logic [W-1:0] skid_data_nxt;

  // Next-state for the two entries. in_ready mirrors an empty skid entry, so
  // an accepted input never coincides with a full skid entry.
  always_comb begin
    in_fire        = in_valid && in_ready;
    out_fire       = out_valid && out_ready;
    out_valid_nxt  = out_valid;
    out_data_nxt   = out_data;
    skid_valid_nxt = skid_valid;
    skid_data_nxt  = skid_data;
    if (!out_valid || out_fire) begin
      // Output register is free this edge: the older skid entry goes first.
      if (skid_valid) begin
        out_valid_nxt  = 1'b1;
        out_data_nxt   = skid_data;
        skid_valid_nxt = 1'b0;
      end else if (in_fire) begin
        out_valid_nxt = 1'b1;
        out_data_nxt  = in_data;
      end else begin
        out_valid_nxt = 1'b0;
      end
    end else begin
      // Output stalled: a newly accepted word parks in the skid entry.
      if (in_fire) begin
        skid_valid_nxt = 1'b1;
        skid_data_nxt  = in_data;
      end else begin
        skid_valid_nxt = skid_valid;
      end
    end
  end

  // State registers, including the registered upstream ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= {W{1'b0}};
      skid_valid <= 1'b0;
      skid_data  <= {W{1'b0}};
      in_ready   <= 1'b0;
    end else begin
      out_valid  <= out_valid_nxt;
      out_data   <= out_data_nxt;
      skid_valid <= skid_valid_nxt;
      skid_data  <= skid_data_nxt;
      in_ready   <= !skid_valid_nxt;
    end
  end

endmodule

// File: rtl/instr_decoder.sv
// instr_decoder
// Decode stage between fetch and execute. Decodes 19-bit instruction words
// into ALU control and register fields, buffers them in a two-entry skid
// stage, counts illegal instructions and, optionally, stalls issue on
// read-after-write hazards.
// Build option: define DEC_HAZARD_EN to enable the register scoreboard.
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   if_valid/if_ready        - fetch handshake (if_ready is registered)
//   if_instr                 - instruction word
//   id_valid/id_ready        - execute handshake
//   id_alu_ctrl, id_rd, id_rs1, id_rs2, id_use_rs2, id_illegal - decoded fields
//   wb_valid, wb_rd          - writeback, clears scoreboard entries
//   illegal_cnt              - saturating count of illegal instructions issued
module instr_decoder
  import instr_decoder_pkg::*;
#(
  parameter int NREG = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_valid,
  output logic               if_ready,
  input  logic [INSTR_W-1:0] if_instr,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [OPC_W-1:0]   id_alu_ctrl,
  output logic [REG_W-1:0]   id_rd,
  output logic [REG_W-1:0]   id_rs1,
  output logic [REG_W-1:0]   id_rs2,
  output logic               id_use_rs2,
  output logic               id_illegal,
  input  logic               wb_valid,
  input  logic [REG_W-1:0]   wb_rd,
  output logic [7:0]         illegal_cnt
);

  dec_t             in_dec;
  dec_t             out_dec;
  logic [DEC_W-1:0] buf_data;
  logic             buf_valid;
  logic             buf_ready;
  logic             stall;
  logic             out_fire;

  assign in_dec = decode_instr(if_instr);

  skid_buffer #(
    .W (DEC_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (if_valid),
    .in_ready  (if_ready),
    .in_data   (in_dec),
    .out_valid (buf_valid),
    .out_ready (buf_ready),
    .out_data  (buf_data)
  );

  assign out_dec = dec_t'(buf_data);

  // A hazard hides the held instruction and freezes the output register.
  assign id_valid  = buf_valid && !stall;
  assign buf_ready = id_ready && !stall;
  assign out_fire  = id_valid && id_ready;

  assign id_alu_ctrl = out_dec.alu_ctrl;
  assign id_rd       = out_dec.rd;
  assign id_rs1      = out_dec.rs1;
  assign id_rs2      = out_dec.rs2;
  assign id_use_rs2  = out_dec.use_rs2;
  assign id_illegal  = out_dec.illegal;

`ifdef DEC_HAZARD_EN
  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_nxt;

  // Hazard check against the registered mask; illegal instructions never wait.
  always_comb begin
    stall = 1'b0;
    if (buf_valid && !out_dec.illegal) begin
      stall = pending[out_dec.rs1]
            | (out_dec.use_rs2 & pending[out_dec.rs2])
            | pending[out_dec.rd];
    end else begin
      stall = 1'b0;
    end
  end

  // Scoreboard update: clear applied first so a same-cycle set wins.
  always_comb begin
    pending_nxt = pending;
    if (wb_valid) begin
      pending_nxt[wb_rd] = 1'b0;
    end else begin
      pending_nxt = pending;
    end
    if (out_fire && !out_dec.illegal) begin
      pending_nxt[out_dec.rd] = 1'b1;
    end else begin
      pending_nxt[out_dec.rd] = pending_nxt[out_dec.rd];
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= {NREG{1'b0}};
    end else begin
      pending <= pending_nxt;
    end
  end
`else
  logic unused_wb;
  assign unused_wb = wb_valid ^ (^wb_rd);
  assign stall     = 1'b0;
`endif

  // Saturating illegal-instruction counter, stepped on output transfers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_cnt <= 8'd0;
    end else if (out_fire && out_dec.illegal && (illegal_cnt != 8'hFF)) begin
      illegal_cnt <= illegal_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_instr_decoder.sv
// tb_instr_decoder
// Directed self-checking bench for instr_decoder. Inputs change 1 ns after
// the rising edge; outputs are sampled at that same point.
module tb_instr_decoder;

  localparam logic [4:0] OP_ADD = 5'd1;
  localparam logic [4:0] OP_SUB = 5'd2;
  localparam logic [4:0] OP_INC = 5'd5;
  localparam logic [4:0] OP_XOR = 5'd9;
  localparam logic [4:0] OP_BAD = 5'd31;

  // Decode table: opcode, expected use_rs2, expected illegal
  localparam logic [4:0] DEC_OPS  [13] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7,
                                          5'd8, 5'd9, 5'd10, 5'd11, 5'd0, 5'd12};
  localparam logic       DEC_USE2 [13] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1,
                                          1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic       DEC_ILL  [13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                          1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  logic        clk;
  logic        rst;
  logic        if_valid;
  logic        if_ready;
  logic [18:0] if_instr;
  logic        id_valid;
  logic        id_ready;
  logic [4:0]  id_alu_ctrl;
  logic [3:0]  id_rd;
  logic [3:0]  id_rs1;
  logic [3:0]  id_rs2;
  logic        id_use_rs2;
  logic        id_illegal;
  logic        wb_valid;
  logic [3:0]  wb_rd;
  logic [7:0]  illegal_cnt;

  int checks;
  int errors;

  instr_decoder dut (
    .clk         (clk),
    .rst         (rst),
    .if_valid    (if_valid),
    .if_ready    (if_ready),
    .if_instr    (if_instr),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_alu_ctrl (id_alu_ctrl),
    .id_rd       (id_rd),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs2  (id_use_rs2),
    .id_illegal  (id_illegal),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .illegal_cnt (illegal_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [18:0] mk(input logic [4:0] op, input logic [3:0] rd,
                                     input logic [3:0] rs1, input logic [3:0] rs2);
    return {op, rd, rs1, rs2, 2'b00};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; if_valid = 1'b0; if_instr = 19'd0; id_ready = 1'b0;
    wb_valid = 1'b0; wb_rd = 4'd0;
    step(); step();
    checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL reset_if_ready: got %0b expected 0", if_ready); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_id_valid: got %0b expected 0", id_valid); end
    checks++; if (illegal_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", illegal_cnt); end
    checks++; if (id_alu_ctrl !== 5'd0) begin errors++; $display("FAIL reset_alu: got %0d expected 0", id_alu_ctrl); end
    rst = 1'b0;
    step();
    checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_rise: got %0b expected 1", if_ready); end
  endtask

  task automatic test_single();
    id_ready = 1'b1;
    if_valid = 1'b1; if_instr = mk(OP_ADD, 4'd3, 4'd1, 4'd2);
    step();
    if_valid = 1'b0;
    checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %0b expected 1", id_valid); end
    checks++; if (id_alu_ctrl !== OP_ADD) begin errors++; $display("FAIL single_alu: got %0d expected %0d", id_alu_ctrl, OP_ADD); end
    checks++; if (id_use_rs2 !== 1'b1) begin errors++; $display("FAIL single_use_rs2: got %0b expected 1", id_use_rs2); end
    checks++; if (id_illegal !== 1'b0) begin errors++; $display("FAIL single_illegal: got %0b expected 0", id_illegal); end
    checks++; if ({id_rd, id_rs1, id_rs2} !== {4'd3, 4'd1, 4'd2}) begin
      errors++; $display("FAIL single_regs: got %0d/%0d/%0d expected 3/1/2", id_rd, id_rs1, id_rs2);
    end
    step();
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got %0b expected 0", id_valid); end
  endtask

  task automatic test_decode();
    logic [4:0] alu_exp;
    id_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL decode_if_ready[%0d]: got %0b expected 1", i, if_ready); end
      if_valid = 1'b1;
      if_instr = mk(DEC_OPS[i], 4'(i), 4'(i + 1), 4'(i + 2));
      step();
      alu_exp = DEC_ILL[i] ? 5'd0 : DEC_OPS[i];
      checks++; if (id_valid !== 1'b1 || id_rd !== 4'(i)) begin
        errors++; $display("FAIL decode_valid[%0d]: got v=%0b rd=%0d expected v=1 rd=%0d", i, id_valid, id_rd, i);
      end
      checks++; if (id_alu_ctrl !== alu_exp) begin errors++; $display("FAIL decode_alu[%0d]: got %0d expected %0d", i, id_alu_ctrl, alu_exp); end
      checks++; if (id_use_rs2 !== DEC_USE2[i]) begin errors++; $display("FAIL decode_use_rs2[%0d]: got %0b expected %0b", i, id_use_rs2, DEC_USE2[i]); end
      checks++; if (id_illegal !== DEC_ILL[i]) begin errors++; $display("FAIL decode_illegal[%0d]: got %0b expected %0b", i, id_illegal, DEC_ILL[i]); end
    end
    if_valid = 1'b0;
    step();
    checks++; if (illegal_cnt !== 8'd2) begin errors++; $display("FAIL decode_cnt: got %0d expected 2", illegal_cnt); end
  endtask

  task automatic test_back_pressure();
    int   sent;
    int   got;
    logic pre;
    sent = 0;
    id_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if_valid = (sent < 4);
      if_instr = mk(OP_XOR, 4'(sent), 4'd1, 4'd2);
      pre = if_ready;
      step();
      if (if_valid && pre) sent++;
    end
    checks++; if (sent != 2) begin errors++; $display("FAIL bp_accepted: got %0d expected 2", sent); end
    checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL bp_if_ready: got %0b expected 0", if_ready); end
    checks++; if (id_valid !== 1'b1 || id_rd !== 4'd0) begin
      errors++; $display("FAIL bp_hold: got v=%0b rd=%0d expected v=1 rd=0", id_valid, id_rd);
    end
    id_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      if (id_valid) begin
        checks++; if (id_rd !== 4'(got) || id_alu_ctrl !== OP_XOR) begin
          errors++; $display("FAIL bp_order: got rd=%0d alu=%0d expected rd=%0d alu=%0d", id_rd, id_alu_ctrl, got, OP_XOR);
        end
        got++;
      end else if (got > 0) begin
        checks++; errors++; $display("FAIL bp_gap: got id_valid=0 expected 1 after %0d outputs", got);
      end
      if_valid = (sent < 4);
      if_instr = mk(OP_XOR, 4'(sent), 4'd1, 4'd2);
      pre = if_ready;
      step();
      if (if_valid && pre) sent++;
    end
    checks++; if (got != 4) begin errors++; $display("FAIL bp_count: got %0d expected 4", got); end
    if_valid = 1'b0;
    step();
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL bp_dup: got id_valid=%0b expected 0", id_valid); end
  endtask

  task automatic test_illegal();
    int   acc;
    logic pre;
    id_ready = 1'b1;
    if_valid = 1'b1; if_instr = mk(OP_BAD, 4'd4, 4'd5, 4'd6);
    step();
    if_valid = 1'b0;
    checks++; if (id_valid !== 1'b1 || id_illegal !== 1'b1) begin
      errors++; $display("FAIL illegal_flag: got v=%0b ill=%0b expected 1/1", id_valid, id_illegal);
    end
    checks++; if (id_alu_ctrl !== 5'd0) begin errors++; $display("FAIL illegal_alu: got %0d expected 0", id_alu_ctrl); end
    step();
    checks++; if (illegal_cnt !== 8'd3) begin errors++; $display("FAIL illegal_cnt_inc: got %0d expected 3", illegal_cnt); end
    acc = 0;
    if_valid = 1'b1;
    for (int c = 0; c < 400 && acc < 299; c++) begin
      pre = if_ready;
      step();
      if (pre) acc++;
    end
    if_valid = 1'b0;
    step(); step();
    checks++; if (acc != 299) begin errors++; $display("FAIL illegal_stream: got %0d accepted expected 299", acc); end
    checks++; if (illegal_cnt !== 8'd255) begin errors++; $display("FAIL illegal_saturate: got %0d expected 255", illegal_cnt); end
  endtask

  task automatic test_reset_mid();
    id_ready = 1'b0;
    if_valid = 1'b1; if_instr = mk(OP_ADD, 4'd7, 4'd0, 4'd0);
    step();
    if_instr = mk(OP_ADD, 4'd8, 4'd0, 4'd0);
    step();
    if_valid = 1'b0;
    checks++; if (if_ready !== 1'b0 || id_valid !== 1'b1) begin
      errors++; $display("FAIL mid_full: got rdy=%0b v=%0b expected 0/1", if_ready, id_valid);
    end
    rst = 1'b1;
    #1;
    checks++; if (id_valid !== 1'b0 || if_ready !== 1'b0) begin
      errors++; $display("FAIL mid_reset_now: got v=%0b rdy=%0b expected 0/0", id_valid, if_ready);
    end
    checks++; if (illegal_cnt !== 8'd0) begin errors++; $display("FAIL mid_reset_cnt: got %0d expected 0", illegal_cnt); end
    step();
    rst = 1'b0;
    step();
    checks++; if (if_ready !== 1'b1 || id_valid !== 1'b0) begin
      errors++; $display("FAIL mid_after: got rdy=%0b v=%0b expected 1/0", if_ready, id_valid);
    end
    id_ready = 1'b1;
    if_valid = 1'b1; if_instr = mk(OP_SUB, 4'd9, 4'd10, 4'd11);
    step();
    if_valid = 1'b0;
    checks++; if (id_valid !== 1'b1 || id_rd !== 4'd9 || id_alu_ctrl !== OP_SUB) begin
      errors++; $display("FAIL mid_first: got v=%0b rd=%0d alu=%0d expected 1/9/%0d", id_valid, id_rd, id_alu_ctrl, OP_SUB);
    end
    step();
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL mid_stale: got id_valid=%0b expected 0", id_valid); end
  endtask

`ifdef DEC_HAZARD_EN
  task automatic test_hazard();
    id_ready = 1'b1;
    if_valid = 1'b1; if_instr = mk(OP_INC, 4'd5, 4'd0, 4'd0);
    step();
    checks++; if (id_valid !== 1'b1 || id_alu_ctrl !== OP_INC) begin
      errors++; $display("FAIL haz_inc: got v=%0b alu=%0d expected 1/%0d", id_valid, id_alu_ctrl, OP_INC);
    end
    if_instr = mk(OP_SUB, 4'd6, 4'd5, 4'd1);
    step();
    if_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL haz_stall[%0d]: got %0b expected 0", c, id_valid); end
      step();
    end
    wb_valid = 1'b1; wb_rd = 4'd5;
    #1;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL haz_wb_cycle: got %0b expected 0", id_valid); end
    step();
    wb_valid = 1'b0;
    checks++; if (id_valid !== 1'b1 || id_alu_ctrl !== OP_SUB || id_rs1 !== 4'd5) begin
      errors++; $display("FAIL haz_release: got v=%0b alu=%0d rs1=%0d expected 1/%0d/5", id_valid, id_alu_ctrl, id_rs1, OP_SUB);
    end
    step();
    wb_valid = 1'b1; wb_rd = 4'd6;
    step();
    wb_valid = 1'b0;
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_decode();
    test_back_pressure();
    test_illegal();
    test_reset_mid();
`ifdef DEC_HAZARD_EN
    test_hazard();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
